// File: rtl/rv32_fetch_unit_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- shown to the decoder whenever no fetched word is held
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch stage and imem.
// Latency: wires only.
// Backpressure: request side uses valid/ready; response side has no ready (fetch accepts whenever waiting).
interface rv32_fetch_unit_if;
    import rv32_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );

endinterface

// File: rtl/rv32_fetch_unit_pc_next_sel.sv
// Next-PC selection: sequential pc+4 or decoder-selected target, plus alignment check.
// Latency: purely combinational.
// Backpressure: none.
module pc_next_sel
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] next_pc,
    output logic            next_misalign
);

    // target bits [1:0] only matter when the target is actually selected
    always_comb begin
        next_pc       = pc_src ? pc_target : (pc + XLEN'(4));
        next_misalign = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/rv32_fetch_unit.sv
// Fetch stage: one outstanding imem request, holds returned word for decoder until retire.
// Latency: retire -> next inst_valid in 3 cycles minimum (REQ, WAIT, HOLD).
// Backpressure: imem_addr held while req_valid && !ready; decoder stalls by withholding retire.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC = rv32_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = rv32_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_src,
    input  logic [31:0]         pc_target,
    input  logic                retire,
    rv32_fetch_unit_if.master   imem,
    output logic [31:0]         inst,
    output logic                inst_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                halted,
    output logic                misalign,
    output logic                fetch_err,
    output logic [31:0]         instret
);
    import rv32_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] next_pc;
    logic        next_misalign;
    logic        req_valid_q;
    logic        req_valid_d;
    logic        halted_d;
    logic        rsp_fire;
    logic        retire_fire;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .pc_src        (pc_src),
        .pc_target     (pc_target),
        .next_pc       (next_pc),
        .next_misalign (next_misalign)
    );

    // responses count only while waiting; retire counts only while holding
    assign rsp_fire    = (state_q == ST_WAIT) && imem.imem_rsp_valid;
    assign retire_fire = (state_q == ST_HOLD) && retire;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (imem.imem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (imem.imem_rsp_valid) state_d = imem.imem_rsp_err ? ST_HALT : ST_HOLD;
            ST_HOLD: if (retire) state_d = next_misalign ? ST_HALT : ST_REQ;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // control outputs decoded from the upcoming state so they can be registered
    always_comb begin
        req_valid_d = (state_d == ST_REQ);
        halted_d    = (state_d == ST_HALT);
    end

    // registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            halted      <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            halted      <= halted_d;
        end
    end

    // datapath: pc, held instruction, sticky causes and retirement counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            fetch_err  <= 1'b0;
            instret    <= '0;
        end else begin
            if (rsp_fire) begin
                if (imem.imem_rsp_err) begin
                    fetch_err <= 1'b1;
                end else begin
                    inst       <= imem.imem_rsp_data;
                    inst_valid <= 1'b1;
                end
            end
            if (retire_fire) begin
                // the retiring instruction completed even if its successor is bad
                instret    <= instret + 32'd1;
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
                if (next_misalign) begin
                    misalign <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_addr      = pc;
    assign pc_plus4            = pc + 32'd4;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Scoreboard bench for rv32_fetch_unit: random fetch/retire traffic against a PC-level model.
// Latency: checks 1-cycle request after reset and 3-cycle retire-to-valid minimum.
// Backpressure: randomised imem ready/response delays, spurious responses and stray retires.
module tb_rv32_fetch_unit;
    import rv32_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        retire;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misalign;
    logic        fetch_err;
    logic [31:0] instret;

    rv32_fetch_unit_if imem_if ();

    rv32_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .retire     (retire),
        .imem       (imem_if),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .halted     (halted),
        .misalign   (misalign),
        .fetch_err  (fetch_err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    fetch_t      exp_inst_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    bit          m_halt;
    bit          m_mis;
    bit          m_ferr;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_inst_q.delete();
        exp_addr_q.delete();
        m_pc      = RST_PC;
        m_instret = 32'd0;
        m_halt    = 1'b0;
        m_mis     = 1'b0;
        m_ferr    = 1'b0;
        exp_addr_q.push_back(RST_PC);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"},        pc, RST_PC);
        chk({tag, "_inst"},      inst, NOP);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_req_valid"}, 32'(imem_if.imem_req_valid), 32'd0);
        chk({tag, "_halted"},    32'(halted), 32'd0);
        chk({tag, "_misalign"},  32'(misalign), 32'd0);
        chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
        chk({tag, "_instret"},   instret, 32'd0);
    endtask

    task automatic check_model();
        chk("model_pc",        pc, m_pc);
        chk("model_pc_plus4",  pc_plus4, m_pc + 32'd4);
        chk("model_instret",   instret, m_instret);
        chk("model_halted",    32'(halted), 32'(m_halt));
        chk("model_misalign",  32'(misalign), 32'(m_mis));
        chk("model_fetch_err", 32'(fetch_err), 32'(m_ferr));
    endtask

    // imem responder: ready after rdly cycles, response after wdly wait cycles
    task automatic serve_fetch(input int rdly, input int wdly, input bit err, input logic [31:0] data);
        int n;
        n = 0;
        while (imem_if.imem_req_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("req_seen", 32'(imem_if.imem_req_valid), 32'd1);
        if (imem_if.imem_req_valid !== 1'b1) return;
        chk("req_addr_model", imem_if.imem_addr, m_pc);
        for (int i = 0; i < rdly; i++) begin
            imem_if.imem_req_ready = 1'b0;
            imem_if.imem_rsp_valid = (i == 0);
            imem_if.imem_rsp_data  = $urandom;
            imem_if.imem_rsp_err   = 1'($urandom % 2);
            retire    = 1'($urandom % 2);
            pc_src    = 1'($urandom % 2);
            pc_target = $urandom;
            cyc();
            chk("bp_addr",       imem_if.imem_addr, m_pc);
            chk("bp_req_valid",  32'(imem_if.imem_req_valid), 32'd1);
            chk("bp_inst",       inst, NOP);
            chk("bp_inst_valid", 32'(inst_valid), 32'd0);
        end
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_err   = 1'b0;
        retire                 = 1'b0;
        imem_if.imem_req_ready = 1'b1;
        cyc();
        imem_if.imem_req_ready = 1'b0;
        chk("req_dropped", 32'(imem_if.imem_req_valid), 32'd0);
        for (int i = 0; i < wdly; i++) begin
            retire = 1'($urandom % 2);
            cyc();
            chk("wait_inst_valid", 32'(inst_valid), 32'd0);
            chk("wait_inst",       inst, NOP);
            chk("wait_addr",       imem_if.imem_addr, m_pc);
        end
        retire = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = data;
        imem_if.imem_rsp_err   = err;
        if (err) begin
            m_ferr = 1'b1;
            m_halt = 1'b1;
        end else begin
            exp_inst_q.push_back('{pc: m_pc, inst: data});
        end
        cyc();
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_err   = 1'b0;
    endtask

    task automatic do_retire(input bit src, input logic [31:0] tgt);
        logic [31:0] nxt;
        int hold;
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            retire = 1'b0;
            cyc();
            chk("hold_inst_valid", 32'(inst_valid), 32'd1);
            chk("hold_pc", pc, m_pc);
        end
        chk("pre_retire_inst_valid", 32'(inst_valid), 32'd1);
        nxt       = src ? tgt : m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        if (nxt % 4 != 0) begin
            m_mis  = 1'b1;
            m_halt = 1'b1;
        end else begin
            m_pc = nxt;
            exp_addr_q.push_back(nxt);
        end
        pc_src    = src;
        pc_target = tgt;
        retire    = 1'b1;
        cyc();
        retire    = 1'b0;
        pc_src    = 1'($urandom % 2);
        pc_target = $urandom;
        check_model();
        chk("post_retire_inst_valid", 32'(inst_valid), 32'd0);
        chk("post_retire_inst", inst, NOP);
    endtask

    // monitor: pops expected request addresses and fetched words as the DUT presents them
    initial begin : monitor
        logic        prev_rv;
        logic        prev_iv;
        logic [31:0] prev_addr;
        logic [31:0] ea;
        fetch_t      e;
        prev_rv   = 1'b0;
        prev_iv   = 1'b0;
        prev_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_rv = 1'b0;
                prev_iv = 1'b0;
                continue;
            end
            if (prev_rv && imem_if.imem_req_ready) begin
                chk("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    ea = exp_addr_q.pop_front();
                    chk("req_addr", prev_addr, ea);
                end
            end
            if (inst_valid && !prev_iv) begin
                chk("inst_expected", 32'(exp_inst_q.size() != 0), 32'd1);
                if (exp_inst_q.size() != 0) begin
                    e = exp_inst_q.pop_front();
                    chk("inst_data", inst, e.inst);
                    chk("inst_pc", pc, e.pc);
                end
            end
            prev_rv   = imem_if.imem_req_valid;
            prev_addr = imem_if.imem_addr;
            prev_iv   = inst_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] pc_before;
        rst_n = 1'b0;
        pc_src = 1'b0;
        pc_target = 32'd0;
        retire = 1'b0;
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = 32'd0;
        imem_if.imem_rsp_err   = 1'b0;
        model_reset();
        repeat (3) cyc();
        check_reset("rst");

        // reset release and first fetch: req one cycle later, word held three cycles later
        rst_n = 1'b1;
        model_reset();
        chk("first_req_idle", 32'(imem_if.imem_req_valid), 32'd0);
        cyc();
        chk("first_req_valid", 32'(imem_if.imem_req_valid), 32'd1);
        chk("first_req_addr", imem_if.imem_addr, 32'h0);
        serve_fetch(0, 0, 1'b0, 32'h0050_0093);
        chk("first_inst", inst, 32'h0050_0093);
        chk("first_inst_valid", 32'(inst_valid), 32'd1);

        // sequential fetch up to pc 0x10, then one more step
        repeat (4) begin
            do_retire(1'b0, $urandom);
            serve_fetch($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, $urandom);
        end
        chk("seq_pc_0x10", pc, 32'h10);
        do_retire(1'b0, 32'h0000_0203);
        chk("seq_addr", imem_if.imem_addr, 32'h14);
        chk("seq_pc_plus4", pc_plus4, 32'h18);
        chk("seq_instret", instret, 32'd5);
        serve_fetch(1, 1, 1'b0, $urandom);

        // branch taken
        do_retire(1'b1, 32'h200);
        chk("br_addr", imem_if.imem_addr, 32'h200);
        serve_fetch(2, 3, 1'b0, $urandom);

        // long backpressure on request and response
        do_retire(1'b0, $urandom);
        serve_fetch(5, 4, 1'b0, $urandom);

        // pc wraps modulo 2^32
        do_retire(1'b1, 32'hFFFF_FFFC);
        serve_fetch(0, 1, 1'b0, $urandom);
        do_retire(1'b0, 32'h0000_0001);
        chk("wrap_pc", pc, 32'h0);
        serve_fetch(1, 0, 1'b0, $urandom);

        // random aligned traffic
        for (int i = 0; i < 40; i++) begin
            do_retire(1'($urandom % 2), $urandom & 32'hFFFF_FFFC);
            serve_fetch($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, $urandom);
        end

        // misaligned target halts with pc unchanged
        pc_before = m_pc;
        do_retire(1'b1, 32'h102);
        chk("mis_pc_unchanged", pc, pc_before);
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_flag", 32'(misalign), 32'd1);
        for (int i = 0; i < 6; i++) begin
            imem_if.imem_rsp_valid = (i % 2 == 0);
            imem_if.imem_rsp_data  = $urandom;
            imem_if.imem_req_ready = 1'b1;
            retire = 1'b1;
            cyc();
            chk("halt_no_req", 32'(imem_if.imem_req_valid), 32'd0);
            chk("halt_inst_valid", 32'(inst_valid), 32'd0);
            chk("halt_inst", inst, NOP);
            check_model();
        end
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_req_ready = 1'b0;
        retire = 1'b0;

        // reset out of HALT, then a bus error
        rst_n = 1'b0;
        #1;
        check_reset("rst_mis");
        cyc();
        rst_n = 1'b1;
        model_reset();
        cyc();
        serve_fetch(0, 0, 1'b0, $urandom);
        do_retire(1'b0, $urandom);
        serve_fetch(1, 2, 1'b1, $urandom);
        check_model();
        chk("err_halted", 32'(halted), 32'd1);
        chk("err_flag", 32'(fetch_err), 32'd1);
        chk("err_inst_valid", 32'(inst_valid), 32'd0);
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = $urandom;
        cyc();
        imem_if.imem_rsp_valid = 1'b0;
        chk("err_late_rsp_ignored", 32'(inst_valid), 32'd0);
        check_model();

        // reset in HALT restarts fetching normally
        rst_n = 1'b0;
        #1;
        check_reset("rst_err");
        cyc();
        rst_n = 1'b1;
        model_reset();
        cyc();
        serve_fetch(0, 0, 1'b0, $urandom);
        chk("restart_pc", pc, RST_PC);
        chk("restart_inst_valid", 32'(inst_valid), 32'd1);
        do_retire(1'b0, $urandom);

        // reset in WAIT; a response arriving in IDLE/REQ afterwards is dropped
        imem_if.imem_req_ready = 1'b1;
        cyc();
        imem_if.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("rst_wait");
        cyc();
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        model_reset();
        cyc();
        cyc();
        imem_if.imem_rsp_valid = 1'b0;
        chk("stale_rsp_inst_valid", 32'(inst_valid), 32'd0);
        chk("stale_rsp_inst", inst, NOP);
        serve_fetch(0, 1, 1'b0, $urandom);
        check_model();

        repeat (2) cyc();
        chk("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_fetch_unit.md
# rv32_fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. It holds the program counter and issues one request at a time to instruction memory over a valid/ready handshake. It presents the returned word, stable, to the decoder until the core signals retirement, then advances the PC to either PC+4 or the branch/jump target, as selected by the decoder's `pc_src`. It also detects misaligned targets and fetch errors, and counts retired instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `NOP_INST`, default 32'h0000_0013: value driven on `inst` whenever no fetched word is held (`addi x0,x0,0`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_src`  in  1  from decoder; 1 means next PC is `pc_target`.
- `pc_target`  in  32  branch/jump target from the ALU/adder.
- `retire`  in  1  current instruction completes this cycle; sampled only in HOLD.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  fetch address; equal to `pc`.
- `imem_rsp_valid`  in  1  response word valid.
- `imem_rsp_data`  in  32  fetched instruction.
- `imem_rsp_err`  in  1  bus error; qualified by `imem_rsp_valid`.
- `inst`  out  32  instruction to the decoder.
- `inst_valid`  out  1  `inst` holds a fetched word.
- `pc`  out  32  address of `inst`.
- `pc_plus4`  out  32  `pc + 4`, for JAL/JALR link.
- `halted`  out  1  sticky stop.
- `misalign`  out  1  sticky; halt cause was a misaligned target.
- `fetch_err`  out  1  sticky; halt cause was a bus error.
- `instret`  out  32  retired-instruction count.

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE is entered only from reset and always moves to REQ on the next cycle.
- **REQ:** `imem_req_valid` = 1.
  - On `imem_req_ready` = 1, go to WAIT.
  - `imem_rsp_valid` is ignored while in REQ.
- **WAIT:** on `imem_rsp_valid` = 1:
  - If `imem_rsp_err` = 1: set `fetch_err`, go to HALT.
  - Otherwise: capture `imem_rsp_data` into `inst`, set `inst_valid`, go to HOLD.
- **HOLD:** `inst`, `pc` and `inst_valid` are held stable. On `retire` = 1:
  - `next = pc_src ? pc_target : pc + 4`.
  - If `next[1:0]` != 0: set `misalign`, go to HALT; `pc` is unchanged.
  - Otherwise: `pc` <= `next`, `inst` <= `NOP_INST`, `inst_valid` <= 0, go to REQ.
  - In both cases `instret` increments, since the retiring instruction did complete.
- **HALT:** absorbing until reset.
  - `halted` = 1, `imem_req_valid` = 0, `inst_valid` = 0, `inst` = `NOP_INST`.
  - Later `imem_rsp_valid` pulses are ignored.
- `retire` outside HOLD has no effect.
- PC arithmetic is modulo 2^32: `pc` = 0xFFFF_FFFC with `pc_src` = 0 wraps to 0.
- `instret` wraps from 0xFFFF_FFFF to 0.
- `pc_target[1:0]` is checked only when `pc_src` = 1.

## Timing
- Reset values: state IDLE, `pc` = `RESET_PC`, `inst` = `NOP_INST`, `inst_valid` = 0, `imem_req_valid` = 0, `halted` = `misalign` = `fetch_err` = 0, `instret` = 0.
- All outputs come from registers, except:
  - `imem_addr` = `pc`.
  - `pc_plus4` = `pc + 4`.
- Minimum latency from `retire` (cycle t) to the next `inst_valid`: 3 cycles.
  - t+1: REQ, with ready.
  - t+2: WAIT, with rsp.
  - t+3: HOLD.
- After reset release, the first `imem_req_valid` is seen 1 cycle later (via IDLE).
- While `imem_req_valid` = 1 without ready, `imem_addr` must not change.
- Only one request is outstanding at any time.
- Reset asserted mid-operation (REQ/WAIT/HOLD/HALT) returns all state to reset values immediately. A response arriving after reset release, while in IDLE/REQ, is dropped.

## Structure
- `rv32_pkg` holds:
  - the state enum,
  - `NOP_INST`,
  - the default `RESET_PC`,
  - the RV32 width constant (32).
- One sub-module, `pc_next_sel`: combinational `next`/misalign computation from `pc`, `pc_src` and `pc_target`. The FSM, handshake, `instret` and sticky flags stay in `rv32_fetch_unit`.

## Test plan
- **Reset and first fetch:** release reset, `RESET_PC` = 0; ready = 1 in REQ, rsp 0x00500093 one cycle later. Require `imem_addr` = 0 and `inst` = 0x00500093 with `inst_valid` = 1 three cycles after reset release.
- **Sequential fetch:** `retire` with `pc_src` = 0 at `pc` = 0x10. Require the next request at 0x14, `pc_plus4` = 0x18, `instret` +1.
- **Branch taken:** `pc_src` = 1, `pc_target` = 0x200, `retire`. Require `imem_addr` = 0x200 and `inst_valid` = 0 until the response arrives.
- **Backpressure:** hold `imem_req_ready` = 0 for 5 cycles, then respond after 4 WAIT cycles. Require `imem_addr` stable throughout and `inst` unchanged until capture.
- **Misaligned target:** `pc_src` = 1, `pc_target` = 0x102, `retire`. Require `halted` = `misalign` = 1, `pc` unchanged, no further requests, `instret` incremented.
- **Bus error and mid-op reset:** `imem_rsp_err` = 1 in WAIT gives `fetch_err`/`halted` = 1. Then assert `rst_n` = 0 in HALT. Require all flags cleared, `pc` = `RESET_PC`, and fetch restarting normally.
